// File: rtl/hack_cpu.sv
// Hack CPU core: A/D/PC registers, instruction decode and a Hack ALU,
// with a mem_ready wait state so slow data memory can stall commit.

module hack_alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);
    logic [15:0] xa, xb, ya, yb, r;

    always_comb begin
        xa  = zx ? 16'h0000 : x;
        xb  = nx ? ~xa : xa;
        ya  = zy ? 16'h0000 : y;
        yb  = ny ? ~ya : ya;
        r   = f ? (xb + yb) : (xb & yb);
        out = no ? ~r : r;
        zr  = (out == 16'h0000);
        ng  = out[15];
    end
endmodule

module hack_cpu #(
    parameter int PC_W = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     instruction,
    input  logic [15:0]     inM,
    input  logic            mem_ready,
    output logic [15:0]     outM,
    output logic            writeM,
    output logic [PC_W-1:0] addressM,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     retired
);
    typedef enum logic {EXEC, WAIT} state_t;

    state_t          state_q, state_d;
    logic [15:0]     a_q, a_d;
    logic [15:0]     d_q, d_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ret_q, ret_d;

    logic        is_c, sel_m, dst_a, dst_d, dst_m;
    logic        j_lt, j_eq, j_gt, jump, mem_acc, commit;
    logic [15:0] alu_y, alu_out;
    logic        alu_zr, alu_ng;
    logic        unused_bits;

    assign is_c  = instruction[15];
    assign sel_m = instruction[12];
    assign dst_a = is_c & instruction[5];
    assign dst_d = is_c & instruction[4];
    assign dst_m = is_c & instruction[3];
    assign j_lt  = instruction[2];
    assign j_eq  = instruction[1];
    assign j_gt  = instruction[0];
    assign unused_bits = ^instruction[14:13];

    assign alu_y = sel_m ? inM : a_q;

    hack_alu u_alu (
        .x   (d_q),
        .y   (alu_y),
        .zx  (instruction[11]),
        .nx  (instruction[10]),
        .zy  (instruction[9]),
        .ny  (instruction[8]),
        .f   (instruction[7]),
        .no  (instruction[6]),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    assign jump = is_c & ((j_lt & alu_ng) | (j_eq & alu_zr) |
                          (j_gt & ~alu_ng & ~alu_zr));

    // A memory instruction commits only once the memory says it is done.
    assign mem_acc = is_c & (sel_m | dst_m);
    assign commit  = ~mem_acc | mem_ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        pc_d    = pc_q;
        ret_d   = ret_q;
        if (commit) begin
            state_d = EXEC;
            ret_d   = ret_q + 16'd1;
            pc_d    = jump ? a_q[PC_W-1:0] : pc_q + 1'b1;
            if (!is_c) a_d = instruction;
            else if (dst_a) a_d = alu_out;
            if (dst_d) d_d = alu_out;
        end else begin
            state_d = WAIT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EXEC;
            a_q     <= '0;
            d_q     <= '0;
            pc_q    <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            d_q     <= d_d;
            pc_q    <= pc_d;
            ret_q   <= ret_d;
        end
    end

    assign outM     = alu_out;
    assign writeM   = dst_m & ~reset;
    assign addressM = a_q[PC_W-1:0];
    assign pc       = pc_q;
    assign retired  = ret_q;
endmodule
